unified_mem_arbiter: RTL and testbench

//  Shares one 256x8 byte-addressed memory between the IF stage (word instruction fetch) and the
//  MEM stage (byte/half/word load-store). Sequences Enable/ReadWrite for the level-sensitive RAM,

---
 rtl/unified_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one level-sensitive byte RAM between word instruction fetch and byte/half/word load-store.
// Data wins ties unless the previous grant went to data and the fetch was already waiting.
module unified_mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_instr,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              d_stall,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [2:0] {S_IDLE, S_D_ACC, S_I_ACC, S_RESP, S_ERR} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_data_q, last_data_d;
  logic                if_wait_q, if_wait_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_rw_q, mem_rw_d;
  logic [1:0]          mem_size_q, mem_size_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_din_q, mem_din_d;
  logic                if_ready_q, if_ready_d;
  logic [31:0]         if_instr_q, if_instr_d;
  logic                d_ready_q, d_ready_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                d_err_q, d_err_d;

  logic                d_bad;
  logic                pick_inst;
  logic                pick_data;
  logic [31:0]         load_ext;

  always_comb begin
    d_bad = (d_size == 2'b11) ||
            (d_size == 2'b01 && d_addr[0]) ||
            (d_size == 2'b10 && d_addr[1:0] != 2'b00);
    // if_wait_q is last cycle's if_req: a fetch that was already pending when data won
    pick_inst = if_req && (!d_req || (last_data_q && if_wait_q));
    pick_data = d_req && !pick_inst;
  end

  always_comb begin
    case (mem_size_q)
      2'b00:   load_ext = {24'b0, mem_dout[7:0]};
      2'b01:   load_ext = {16'b0, mem_dout[15:0]};
      default: load_ext = mem_dout;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_data_d  = last_data_q;
    if_wait_d    = if_req;
    mem_enable_d = mem_enable_q;
    mem_rw_d     = mem_rw_q;
    mem_size_d   = mem_size_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    if_ready_d   = 1'b0;
    if_instr_d   = if_instr_q;
    d_ready_d    = 1'b0;
    d_rdata_d    = d_rdata_q;
    d_err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_data) begin
          last_data_d = 1'b1;
          if (d_bad) begin
            state_d   = S_ERR;
            d_ready_d = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = 32'b0;
          end else begin
            state_d      = S_D_ACC;
            cnt_d        = LAT_M1;
            mem_enable_d = 1'b1;
            mem_rw_d     = d_rw;
            mem_size_d   = d_size;
            mem_addr_d   = d_addr;
            mem_din_d    = d_wdata;
          end
        end else if (pick_inst) begin
          last_data_d  = 1'b0;
          state_d      = S_I_ACC;
          cnt_d        = LAT_M1;
          mem_enable_d = 1'b1;
          mem_rw_d     = 1'b0;
          mem_size_d   = 2'b10;
          mem_addr_d   = if_addr;
          mem_din_d    = 32'b0;
        end
      end
      S_D_ACC: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          mem_enable_d = 1'b0;
          d_ready_d    = 1'b1;
          if (!mem_rw_q) d_rdata_d = load_ext;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_I_ACC: begin
        // a dropped fetch aborts even on the final access cycle
        if (!if_req) begin
          state_d      = S_IDLE;
          mem_enable_d = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          mem_enable_d = 1'b0;
          if_ready_d   = 1'b1;
          if_instr_d   = mem_dout;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_data_q  <= 1'b0;
      if_wait_q    <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_size_q   <= 2'b00;
      mem_addr_q   <= '0;
      mem_din_q    <= 32'b0;
      if_ready_q   <= 1'b0;
      if_instr_q   <= 32'b0;
      d_ready_q    <= 1'b0;
      d_rdata_q    <= 32'b0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_data_q  <= last_data_d;
      if_wait_q    <= if_wait_d;
      mem_enable_q <= mem_enable_d;
      mem_rw_q     <= mem_rw_d;
      mem_size_q   <= mem_size_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      if_ready_q   <= if_ready_d;
      if_instr_q   <= if_instr_d;
      d_ready_q    <= d_ready_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  assign if_ready   = if_ready_q;
  assign if_instr   = if_instr_q;
  assign if_stall   = if_req & ~if_ready_q;
  assign d_ready    = d_ready_q;
  assign d_rdata    = d_rdata_q;
  assign d_err      = d_err_q;
  assign d_stall    = d_req & ~d_ready_q;
  assign mem_enable = mem_enable_q;
  assign mem_rw     = mem_rw_q;
  assign mem_size   = mem_size_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios then random traffic, all checked every cycle
// against a schedule-based model of grants, latencies and memory contents.
module tb_unified_mem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_instr;
  logic        if_stall;
  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        d_stall;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  unified_mem_arbiter #(.MEM_LAT(L), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_instr(if_instr), .if_stall(if_stall),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err), .d_stall(d_stall),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Big-endian byte RAM; narrow reads return junk above the accessed bytes
  logic [7:0] ram [256];
  logic [7:0] ra0, ra1, ra2, ra3;
  assign ra0 = mem_addr[7:0];
  assign ra1 = ra0 + 8'd1;
  assign ra2 = ra0 + 8'd2;
  assign ra3 = ra0 + 8'd3;
  always_comb begin
    case (mem_size)
      2'b00:   mem_dout = {24'hA5A5A5, ram[ra0]};
      2'b01:   mem_dout = {16'hA5A5, ram[ra0], ram[ra1]};
      default: mem_dout = {ram[ra0], ram[ra1], ram[ra2], ram[ra3]};
    endcase
  end

  // Reference model state
  logic [7:0]  ref_ram [256];
  int          ecount = 0;
  int          m_busy = 0;   // 0 none, 1 data access, 2 fetch
  int          m_g = 0;
  int          m_next = 0;
  bit          m_last_d = 0;
  bit          m_prev_if = 0;
  logic [31:0] m_addr, m_din;
  logic [1:0]  m_size;
  logic        m_rw;
  logic        exp_if_ready, exp_d_ready, exp_d_err, exp_en, exp_mem_chk;
  logic [31:0] exp_if_instr, exp_d_rdata;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] sz);
    logic [7:0] b0, b1, b2, b3;
    b0 = a[7:0]; b1 = b0 + 8'd1; b2 = b0 + 8'd2; b3 = b0 + 8'd3;
    case (sz)
      2'b00:   return {24'b0, ref_ram[b0]};
      2'b01:   return {16'b0, ref_ram[b0], ref_ram[b1]};
      default: return {ref_ram[b0], ref_ram[b1], ref_ram[b2], ref_ram[b3]};
    endcase
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] v);
    logic [7:0] b0, b1, b2, b3;
    b0 = a[7:0]; b1 = b0 + 8'd1; b2 = b0 + 8'd2; b3 = b0 + 8'd3;
    case (sz)
      2'b00: ref_ram[b0] = v[7:0];
      2'b01: begin ref_ram[b0] = v[15:8]; ref_ram[b1] = v[7:0]; end
      default: begin
        ref_ram[b0] = v[31:24]; ref_ram[b1] = v[23:16];
        ref_ram[b2] = v[15:8];  ref_ram[b3] = v[7:0];
      end
    endcase
  endtask

  task automatic ram_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] v);
    logic [7:0] b0, b1, b2, b3;
    b0 = a[7:0]; b1 = b0 + 8'd1; b2 = b0 + 8'd2; b3 = b0 + 8'd3;
    case (sz)
      2'b00: ram[b0] <= v[7:0];
      2'b01: begin ram[b0] <= v[15:8]; ram[b1] <= v[7:0]; end
      default: begin
        ram[b0] <= v[31:24]; ram[b1] <= v[23:16];
        ram[b2] <= v[15:8];  ram[b3] <= v[7:0];
      end
    endcase
  endtask

  task automatic set_byte(input logic [7:0] a, input logic [7:0] v);
    ram[a] <= v;
    ref_ram[a] = v;
  endtask

  // One clock edge of the model: access occupies edges g..g+L, ready one cycle, then one idle cycle
  task automatic model_edge();
    bit pick_i, pick_d, bad;
    ecount++;
    exp_mem_chk = 1'b0;
    if (reset) begin
      exp_if_ready = 0; exp_d_ready = 0; exp_d_err = 0; exp_en = 0;
      exp_if_instr = 0; exp_d_rdata = 0;
      m_addr = 0; m_size = 0; m_rw = 0; m_din = 0;
      exp_mem_chk = 1'b1;
      m_busy = 0; m_next = ecount + 1; m_last_d = 0; m_prev_if = 0;
      return;
    end
    exp_if_ready = 0; exp_d_ready = 0; exp_d_err = 0;
    if (m_busy != 0) begin
      if (m_busy == 2 && !if_req) begin
        exp_en = 0; m_busy = 0; m_next = ecount + 1;
        $display("[%0d] fetch @%h flushed", ecount, m_addr);
      end else if (ecount == m_g + L) begin
        exp_en = 0; m_next = ecount + 2;
        if (m_busy == 1) begin
          exp_d_ready = 1;
          if (!m_rw) exp_d_rdata = ref_read(m_addr, m_size);
          $display("[%0d] data %s size=%0d @%h wdata=%h rdata=%h", ecount, m_rw ? "store" : "load",
                   m_size, m_addr, m_din, exp_d_rdata);
        end else begin
          exp_if_ready = 1;
          exp_if_instr = ref_read(m_addr, 2'b10);
          $display("[%0d] fetch @%h instr=%h", ecount, m_addr, exp_if_instr);
        end
        m_busy = 0;
      end
    end else if (ecount >= m_next) begin
      pick_i = if_req && (!d_req || (m_last_d && m_prev_if));
      pick_d = d_req && !pick_i;
      if (pick_d) begin
        m_last_d = 1;
        bad = (d_size == 2'b11) || (d_size == 2'b01 && d_addr[0]) ||
              (d_size == 2'b10 && d_addr[1:0] != 2'b00);
        if (bad) begin
          exp_d_ready = 1; exp_d_err = 1; exp_d_rdata = 0; m_next = ecount + 2;
          $display("[%0d] data request size=%0d @%h rejected", ecount, d_size, d_addr);
        end else begin
          m_busy = 1; m_g = ecount; exp_en = 1;
          m_addr = d_addr; m_size = d_size; m_rw = d_rw; m_din = d_wdata;
          if (d_rw) ref_write(d_addr, d_size, d_wdata);
        end
      end else if (pick_i) begin
        m_last_d = 0; m_busy = 2; m_g = ecount; exp_en = 1;
        m_addr = if_addr; m_size = 2'b10; m_rw = 0; m_din = 0;
      end
    end
    m_prev_if = if_req;
    if (exp_en) exp_mem_chk = 1'b1;
  endtask

  task automatic compare();
    chk("if_ready", {31'b0, if_ready}, {31'b0, exp_if_ready});
    chk("if_instr", if_instr, exp_if_instr);
    chk("d_ready", {31'b0, d_ready}, {31'b0, exp_d_ready});
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk("d_err", {31'b0, d_err}, {31'b0, exp_d_err});
    chk("mem_enable", {31'b0, mem_enable}, {31'b0, exp_en});
    chk("if_stall", {31'b0, if_stall}, {31'b0, if_req & ~exp_if_ready});
    chk("d_stall", {31'b0, d_stall}, {31'b0, d_req & ~exp_d_ready});
    if (exp_mem_chk) begin
      chk("mem_rw", {31'b0, mem_rw}, {31'b0, m_rw});
      chk("mem_size", {30'b0, mem_size}, {30'b0, m_size});
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_din", mem_din, m_din);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (mem_enable && mem_rw) ram_write(mem_addr, mem_size, mem_din);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run_until(input bit want_d, output int cyc, output int en, output int wr);
    cyc = 0; en = 0; wr = 0;
    do begin
      step();
      cyc++;
      if (mem_enable) en++;
      if (mem_enable && mem_rw) wr++;
    end while (!(want_d ? d_ready : if_ready) && cyc < 30);
    chk(want_d ? "d_ready_seen" : "if_ready_seen", {31'b0, want_d ? d_ready : if_ready}, 32'd1);
  endtask

  task automatic set_d(input logic rw, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_rw = rw; d_size = sz; d_addr = a; d_wdata = wd;
  endtask

  task automatic new_d();
    logic [31:0] a;
    d_size  = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
    d_rw    = 1'($urandom % 2);
    d_wdata = $urandom;
    a = ($urandom % 4 == 0) ? $urandom : ($urandom & 32'hFF);
    if ($urandom % 5 != 0) begin
      if (d_size == 2'b01) a[0] = 1'b0;
      else if (d_size == 2'b10) a[1:0] = 2'b00;
    end
    d_addr = a;
    d_req  = 1'b1;
  endtask

  task automatic new_if();
    if_addr = ($urandom % 6 == 0) ? $urandom : ($urandom & 32'hFC);
    if_req  = 1'b1;
  endtask

  initial begin
    int cyc, en, wr, n;
    logic [3:0] seq;
    logic [7:0] v;
    reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_rw = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      set_byte(8'(i), v);
    end
    set_byte(8'h10, 8'hE3); set_byte(8'h11, 8'hA0); set_byte(8'h12, 8'h10); set_byte(8'h13, 8'h05);
    set_byte(8'h20, 8'h12); set_byte(8'h21, 8'h34); set_byte(8'h22, 8'h56); set_byte(8'h23, 8'h78);
    set_byte(8'h00, 8'hE1); set_byte(8'h01, 8'hA0); set_byte(8'h02, 8'h00); set_byte(8'h03, 8'h00);
    set_byte(8'h30, 8'hDE); set_byte(8'h31, 8'hAD); set_byte(8'h32, 8'hBE); set_byte(8'h33, 8'hEF);
    set_byte(8'h40, 8'h5C);

    step(); step();
    chk("reset_if_instr", if_instr, 32'h0);
    chk("reset_mem_enable", {31'b0, mem_enable}, 32'h0);
    reset = 1'b0;

    // single fetch
    if_req = 1'b1; if_addr = 32'h10;
    run_until(1'b0, cyc, en, wr);
    chk("fetch_latency", cyc, 32'd3);
    chk("fetch_enable_cycles", en, 32'd2);
    chk("fetch_instr", if_instr, 32'hE3A01005);
    chk("if_stall_at_ready", {31'b0, if_stall}, 32'h0);
    if_req = 1'b0;
    step();

    // simultaneous requests: data first, fetch right after
    set_d(1'b0, 2'b10, 32'h20, 32'h0);
    if_req = 1'b1; if_addr = 32'h0;
    run_until(1'b1, cyc, en, wr);
    chk("both_d_latency", cyc, 32'd3);
    chk("both_d_rdata", d_rdata, 32'h12345678);
    d_req = 1'b0;
    run_until(1'b0, cyc, en, wr);
    chk("both_if_latency", cyc, 32'd4);
    chk("both_if_instr", if_instr, 32'hE1A00000);
    if_req = 1'b0;
    step();

    // both held back-to-back: grants must alternate
    set_d(1'b0, 2'b10, 32'h20, 32'h0);
    if_req = 1'b1; if_addr = 32'h30;
    seq = 4'b0; n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      step();
      if (d_ready) begin seq = {seq[2:0], 1'b1}; n++; end
      if (if_ready) begin seq = {seq[2:0], 1'b0}; n++; end
    end
    chk("grant_order", {28'b0, seq}, 32'hA);
    d_req = 1'b0; if_req = 1'b0;
    step();

    // byte store then half load over it
    set_d(1'b1, 2'b00, 32'h41, 32'h123456AB);
    run_until(1'b1, cyc, en, wr);
    chk("store_rw_cycles", wr, 32'd2);
    d_req = 1'b0;
    step();
    set_d(1'b0, 2'b01, 32'h40, 32'h0);
    run_until(1'b1, cyc, en, wr);
    chk("load_half_rw_cycles", wr, 32'd0);
    chk("load_half_rdata", d_rdata, 32'h00005CAB);
    d_req = 1'b0;
    step();

    // misaligned word load
    set_d(1'b0, 2'b10, 32'h22, 32'h0);
    run_until(1'b1, cyc, en, wr);
    chk("err_latency", cyc, 32'd1);
    chk("err_enable_cycles", en, 32'd0);
    chk("err_flag", {31'b0, d_err}, 32'd1);
    chk("err_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    step();

    // fetch flushed in its first access cycle
    if_req = 1'b1; if_addr = 32'h10;
    step();
    chk("flush_start_enable", {31'b0, mem_enable}, 32'd1);
    if_req = 1'b0;
    step();
    chk("flush_enable", {31'b0, mem_enable}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("flush_no_ready", {31'b0, if_ready}, 32'd0);
    end

    // reset in the middle of a data access
    set_d(1'b0, 2'b10, 32'h20, 32'h0);
    step();
    chk("dacc_enable", {31'b0, mem_enable}, 32'd1);
    reset = 1'b1;
    step();
    chk("rst_mem_enable", {31'b0, mem_enable}, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0; d_req = 1'b0;
    step();

    // random traffic
    for (int k = 0; k < 3000 && n_fail < 200; k++) begin
      step();
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom % 250 == 0) begin
        reset = 1'b1; d_req = 1'b0; if_req = 1'b0;
      end else begin
        if (d_req && d_ready) begin
          if ($urandom % 3 == 0) new_d(); else d_req = 1'b0;
        end else if (!d_req && $urandom % 4 == 0) begin
          new_d();
        end
        if (if_req && if_ready) begin
          if ($urandom % 2 == 0) new_if(); else if_req = 1'b0;
        end else if (if_req) begin
          if ($urandom % 16 == 0) if_req = 1'b0;
        end else if ($urandom % 3 == 0) begin
          new_if();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
